// File: rtl/hazard_control_unit_if.sv
// Pipeline-side signal bundle for the hazard controller: hazard sources in,
// stall/flush/forward controls and the stall counter out.
interface hazard_control_unit_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
);
    logic [REG_ADDR_WIDTH-1:0] Rs1D;
    logic [REG_ADDR_WIDTH-1:0] Rs2D;
    logic [REG_ADDR_WIDTH-1:0] Rs1E;
    logic [REG_ADDR_WIDTH-1:0] Rs2E;
    logic [REG_ADDR_WIDTH-1:0] RdE;
    logic [REG_ADDR_WIDTH-1:0] RdM;
    logic [REG_ADDR_WIDTH-1:0] RdW;
    logic                      RegWriteM;
    logic                      RegWriteW;
    logic                      MemReadE;
    logic                      PCSrcE;
    logic                      imem_ready;
    logic                      MemReqM;
    logic                      dmem_ready;

    logic                      StallF;
    logic                      StallD;
    logic                      StallE;
    logic                      StallM;
    logic                      FlushD;
    logic                      FlushE;
    logic                      FlushW;
    logic [1:0]                ForwardAE;
    logic [1:0]                ForwardBE;
    logic [CNT_WIDTH-1:0]      stall_cycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, MemReadE, PCSrcE,
        output imem_ready, MemReqM, dmem_ready,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, stall_cycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, MemReadE, PCSrcE,
        input  imem_ready, MemReqM, dmem_ready,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, stall_cycles
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding selects,
// load-use and fetch-miss stalls, data-memory waits and stale-fetch discard.
//
// state | meaning
// RUN   | fetch delivering, pipeline flowing
// IMISS | waiting on instruction memory (possibly discarding a stale fetch)
// DWAIT | data memory busy, whole front of pipeline frozen
module hazard_control_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_control_unit_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DWAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 redir_pend_q, redir_pend_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] fwd_a, fwd_b;
    logic       lw_stall;
    logic       dwait;

    always_comb begin
        fwd_a = 2'b00;
        if (hz.RegWriteM && (hz.RdM == hz.Rs1E) && (hz.Rs1E != '0))
            fwd_a = 2'b10;
        else if (hz.RegWriteW && (hz.RdW == hz.Rs1E) && (hz.Rs1E != '0))
            fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (hz.RegWriteM && (hz.RdM == hz.Rs2E) && (hz.Rs2E != '0))
            fwd_b = 2'b10;
        else if (hz.RegWriteW && (hz.RdW == hz.Rs2E) && (hz.Rs2E != '0))
            fwd_b = 2'b01;
    end

    assign lw_stall = hz.MemReadE && (hz.RdE != '0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign dwait    = hz.MemReqM && !hz.dmem_ready;

    always_comb begin
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_w      = 1'b0;
        state_d      = RUN;
        redir_pend_d = redir_pend_q;

        if (dwait) begin
            // E is frozen, so a pending redirect or load-use is simply re-seen on release
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
            state_d = DWAIT;
        end else if (hz.PCSrcE) begin
            flush_d      = 1'b1;
            flush_e      = 1'b1;
            redir_pend_d = !hz.imem_ready;
            state_d      = hz.imem_ready ? RUN : IMISS;
        end else if (redir_pend_q && hz.imem_ready) begin
            // the returning fetch belongs to the pre-redirect address
            flush_d      = 1'b1;
            stall_f      = 1'b1;
            redir_pend_d = 1'b0;
            state_d      = IMISS;
        end else if (!hz.imem_ready) begin
            stall_f = 1'b1;
            state_d = IMISS;
            if (lw_stall) begin
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                flush_d = 1'b1;
            end
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_f && !rst && (stall_cycles_q != {CNT_WIDTH{1'b1}}))
            stall_cycles_d = stall_cycles_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            redir_pend_q   <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            redir_pend_q   <= redir_pend_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.StallF       = stall_f & ~rst;
    assign hz.StallD       = stall_d & ~rst;
    assign hz.StallE       = stall_e & ~rst;
    assign hz.StallM       = stall_m & ~rst;
    assign hz.FlushD       = flush_d & ~rst;
    assign hz.FlushE       = flush_e & ~rst;
    assign hz.FlushW       = flush_w & ~rst;
    assign hz.ForwardAE    = fwd_a;
    assign hz.ForwardBE    = fwd_b;
    assign hz.stall_cycles = stall_cycles_q;

    // a pending stale fetch always implies we are not in plain RUN
    redir_implies_busy: assert property (@(posedge clk) disable iff (rst)
        redir_pend_q |-> (state_q != RUN));

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit: a vector table for
// single-cycle behaviour plus hand sequences for multi-cycle corner cases.
module tb_hazard_control_unit;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_IMISS = 2'd1;
    localparam logic [1:0] S_DWAIT = 2'd2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_control_unit_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) h ();
    hazard_control_unit_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2))  hs ();

    hazard_control_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (h.slave)
    );

    hazard_control_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .hz  (hs.slave)
    );

    assign hs.Rs1D       = h.Rs1D;
    assign hs.Rs2D       = h.Rs2D;
    assign hs.Rs1E       = h.Rs1E;
    assign hs.Rs2E       = h.Rs2E;
    assign hs.RdE        = h.RdE;
    assign hs.RdM        = h.RdM;
    assign hs.RdW        = h.RdW;
    assign hs.RegWriteM  = h.RegWriteM;
    assign hs.RegWriteW  = h.RegWriteW;
    assign hs.MemReadE   = h.MemReadE;
    assign hs.PCSrcE     = h.PCSrcE;
    assign hs.imem_ready = h.imem_ready;
    assign hs.MemReqM    = h.MemReqM;
    assign hs.dmem_ready = h.dmem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, mre, pcs, imr, mrq, dmr;
        logic [3:0] st;
        logic [2:0] fl;
        logic [1:0] fa, fb, ns;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        h.Rs1D = 5'd0; h.Rs2D = 5'd0; h.Rs1E = 5'd0; h.Rs2E = 5'd0;
        h.RdE = 5'd0; h.RdM = 5'd0; h.RdW = 5'd0;
        h.RegWriteM = 1'b0; h.RegWriteW = 1'b0; h.MemReadE = 1'b0;
        h.PCSrcE = 1'b0; h.imem_ready = 1'b1; h.MemReqM = 1'b0; h.dmem_ready = 1'b1;
    endtask

    task automatic set_in(input vec_t v);
        h.Rs1D = v.rs1d; h.Rs2D = v.rs2d; h.Rs1E = v.rs1e; h.Rs2E = v.rs2e;
        h.RdE = v.rde; h.RdM = v.rdm; h.RdW = v.rdw;
        h.RegWriteM = v.rwm; h.RegWriteW = v.rww; h.MemReadE = v.mre;
        h.PCSrcE = v.pcs; h.imem_ready = v.imr; h.MemReqM = v.mrq; h.dmem_ready = v.dmr;
    endtask

    task automatic expect_o(input string tag, input logic [3:0] st, input logic [2:0] fl);
        chk({tag, "_stall"}, {28'd0, h.StallF, h.StallD, h.StallE, h.StallM}, {28'd0, st});
        chk({tag, "_flush"}, {29'd0, h.FlushD, h.FlushE, h.FlushW}, {29'd0, fl});
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clr_in();

        //          rs1d  rs2d  rs1e  rs2e  rde   rdm   rdw   rwm  rww  mre  pcs  imr  mrq  dmr  stall    flush   fa     fb     next
        tbl[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 4'b0000, 3'b000, 2'b00, 2'b00, S_RUN};
        tbl[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 4'b0000, 3'b000, 2'b10, 2'b00, S_RUN};
        tbl[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 4'b0000, 3'b000, 2'b00, 2'b00, S_RUN};
        tbl[3]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 4'b0000, 3'b000, 2'b01, 2'b00, S_RUN};
        tbl[4]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd3, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 4'b0000, 3'b000, 2'b01, 2'b10, S_RUN};
        tbl[5]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd4, 5'd9, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 4'b0000, 3'b000, 2'b00, 2'b01, S_RUN};
        tbl[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 4'b1100, 3'b010, 2'b00, 2'b00, S_RUN};
        tbl[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 4'b0000, 3'b000, 2'b00, 2'b00, S_RUN};
        tbl[8]  = '{5'd7, 5'd2, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 4'b1100, 3'b010, 2'b00, 2'b00, S_RUN};
        tbl[9]  = '{5'd6, 5'd8, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 4'b0000, 3'b000, 2'b00, 2'b00, S_RUN};
        tbl[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'b1000, 3'b100, 2'b00, 2'b00, S_IMISS};
        tbl[11] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 4'b1100, 3'b010, 2'b00, 2'b00, S_IMISS};
        tbl[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 4'b0000, 3'b110, 2'b00, 2'b00, S_RUN};
        tbl[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 4'b1111, 3'b001, 2'b00, 2'b00, S_DWAIT};
        tbl[14] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 4'b1111, 3'b001, 2'b00, 2'b00, S_DWAIT};
        tbl[15] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 4'b1000, 3'b100, 2'b00, 2'b00, S_IMISS};
        tbl[16] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 4'b0000, 3'b000, 2'b00, 2'b00, S_RUN};
        tbl[17] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0, 4'b1111, 3'b001, 2'b00, 2'b00, S_DWAIT};

        do_reset();
        chk("reset_state", 32'(dut.state_q), 32'(S_RUN));
        chk("reset_redir", 32'(dut.redir_pend_q), 32'd0);
        chk("reset_cnt", 32'(h.stall_cycles), 32'd0);
        expect_o("reset_idle", 4'b0000, 3'b000);

        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i]);
            #2;
            expect_o($sformatf("v%0d", i), tbl[i].st, tbl[i].fl);
            chk($sformatf("v%0d_fa", i), 32'(h.ForwardAE), 32'(tbl[i].fa));
            chk($sformatf("v%0d_fb", i), 32'(h.ForwardBE), 32'(tbl[i].fb));
            tick();
            chk($sformatf("v%0d_state", i), 32'(dut.state_q), 32'(tbl[i].ns));
        end

        // load-use for exactly one cycle
        do_reset();
        h.MemReadE = 1'b1; h.RdE = 5'd7; h.Rs2D = 5'd7;
        #2; expect_o("lu_c0", 4'b1100, 3'b010);
        tick();
        clr_in();
        #2; expect_o("lu_c1", 4'b0000, 3'b000);
        chk("lu_cnt", 32'(h.stall_cycles), 32'd1);
        tick();

        // fetch miss for three cycles
        do_reset();
        h.imem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2; expect_o($sformatf("miss_c%0d", c), 4'b1000, 3'b100);
            tick();
            chk($sformatf("miss_c%0d_state", c), 32'(dut.state_q), 32'(S_IMISS));
        end
        h.imem_ready = 1'b1;
        #2; expect_o("miss_rel", 4'b0000, 3'b000);
        tick();
        chk("miss_rel_state", 32'(dut.state_q), 32'(S_RUN));
        chk("miss_cnt", 32'(h.stall_cycles), 32'd3);

        // redirect while a fetch is outstanding, then stale discard
        do_reset();
        h.imem_ready = 1'b0;
        tick();
        h.PCSrcE = 1'b1;
        #2; expect_o("redir_c0", 4'b0000, 3'b110);
        tick();
        chk("redir_c0_pend", 32'(dut.redir_pend_q), 32'd1);
        chk("redir_c0_state", 32'(dut.state_q), 32'(S_IMISS));
        h.PCSrcE = 1'b0; h.imem_ready = 1'b1;
        #2; expect_o("stale_c1", 4'b1000, 3'b100);
        tick();
        chk("stale_c1_pend", 32'(dut.redir_pend_q), 32'd0);
        chk("stale_c1_state", 32'(dut.state_q), 32'(S_IMISS));
        #2; expect_o("stale_c2", 4'b0000, 3'b000);
        tick();
        chk("stale_c2_state", 32'(dut.state_q), 32'(S_RUN));

        // data wait hides a concurrent redirect until release
        do_reset();
        h.MemReqM = 1'b1; h.dmem_ready = 1'b0; h.PCSrcE = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2; expect_o($sformatf("dw_c%0d", c), 4'b1111, 3'b001);
            tick();
            chk($sformatf("dw_c%0d_state", c), 32'(dut.state_q), 32'(S_DWAIT));
        end
        h.dmem_ready = 1'b1;
        #2; expect_o("dw_rel", 4'b0000, 3'b110);
        tick();
        chk("dw_rel_state", 32'(dut.state_q), 32'(S_RUN));
        chk("dw_cnt", 32'(h.stall_cycles), 32'd4);

        // fifth stall cycle: wide counter keeps counting, 2-bit one sticks at 3
        clr_in();
        h.imem_ready = 1'b0;
        tick();
        chk("sat_wide_cnt", 32'(h.stall_cycles), 32'd5);
        chk("sat_narrow_cnt", 32'(hs.stall_cycles), 32'd3);

        // reset asserted in the middle of a data wait
        clr_in();
        h.MemReqM = 1'b1; h.dmem_ready = 1'b0;
        tick();
        chk("rstdw_state", 32'(dut.state_q), 32'(S_DWAIT));
        rst = 1'b1;
        h.Rs1E = 5'd5; h.RdM = 5'd5; h.RegWriteM = 1'b1;
        #2; expect_o("rstdw_out", 4'b0000, 3'b000);
        chk("rstdw_fa", 32'(h.ForwardAE), 32'd2);
        tick();
        rst = 1'b0;
        chk("rstdw_state_after", 32'(dut.state_q), 32'(S_RUN));
        chk("rstdw_cnt", 32'(h.stall_cycles), 32'd0);
        chk("rstdw_narrow_cnt", 32'(hs.stall_cycles), 32'd0);
        clr_in();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
